trigger_sequencer: RTL and testbench
====================================

# trigger_sequencer

Table-driven capture trigger with run control: per-sample matchers and saturating counters feed a programmable state table, and the selected table entry tags each sample with a start/trigger/end event. Sits between the sampler stream and the capture buffer, configured over the write-only system bus. This is the parametrised successor to the fixed-size trigger. It adds:
- arm/disarm control;
- indirect table loading with an auto-incrementing pointer;
- counter limits and clear masks driven from the table;
- a registered, back-pressured output slice.

## Interface
- BDW, 32: bus data width; must be ≥ TEW.
- BAW, 6: bus address width (word addresses).
- SDW, 32: sample data width.
- TMN, 4: number of matchers.
- TCN, 2: number of counters.
- TCW, 16: counter width.
- TSW, 3: state width (2**TSW states).
- TEW, TSW+2*TCN+2: table entry width (derived).
- TAW, TSW+TMN+TCN: table address width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- bus_wready  out  1  always 1
- bus_wvalid  in  1  bus write valid
- bus_waddr  in  BAW  register word address
- bus_wdata  in  BDW  write data
- sti_tready  out  1  input ready
- sti_tvalid  in  1  input valid
- sti_tdata  in  SDW  input sample
- sto_tready  in  1  output ready
- sto_tvalid  out  1  output valid
- sto_tevent  out  2  event tag: 00 none, 01 start, 10 trigger, 11 end
- sto_tdata  out  SDW  output sample
- sts_armed  out  1  sequencer armed

## Operation
Register map; a bus write occurs when bus_wvalid=1:
- 0x00 CTRL: bit0 arm, bit1 disarm. Both are write-1 pulses; if both are set, disarm wins.
- 0x01 TBL_PTR: table write pointer, TAW bits.
- 0x02 TBL_DAT: writes entry[TBL_PTR], then the pointer increments and wraps at 2**TAW.
- 0x03 MODE: edge-mode bit per matcher; see Configuration.
- 0x08+2m: matcher m mask. 0x09+2m: matcher m value.
- 0x20+c: counter c limit.

Configuration writes:
- Writes to 0x01–0x3F are ignored while armed.
- Unmapped addresses are ignored.

Matchers:
- match_m = ((sti_tdata ^ val_m) & msk_m) == 0, evaluated on the current sample.

Counters:
- done_c = (cnt_c == lim_c), taken from the registered counter value.

Table lookup and entry fields:
- Lookup address = {state, match[TMN-1:0], done[TCN-1:0]}.
- Entry fields, LSB first: next_state[TSW], inc[TCN], clr[TCN], evt[2].

On each input transfer while armed:
- state ← next_state.
- Per counter: clr has priority (cnt ← 0). Otherwise, if inc=1 and cnt ≠ lim, cnt ← cnt+1. The counter saturates at lim and does not wrap.
- Output event = evt.
- evt=11 (end) also disarms; the state goes to 0 on the following cycle.

While disarmed:
- state=0, counters=0.
- Samples pass through with event 00.

Arm:
- Sets sts_armed, state=0, counters=0.

Table memory:
- Not reset; software loads it before arming.

## Timing
- Reset values:
  - sto_tvalid=0, sto_tevent=00, sto_tdata=0, sts_armed=0.
  - state, counters, limits, masks, values, MODE and TBL_PTR are all 0.
- Output is a one-deep register slice, so latency is 1 cycle from the input transfer to sto_tvalid.
- sti_tready = ~sto_tvalid | sto_tready, giving full throughput under no back-pressure.
- Under stall, sto_tdata and sto_tevent are held stable while sto_tvalid=1 and sto_tready=0.
- An arm write in the same cycle as an input transfer: that sample is processed as disarmed; the armed state applies from the next transfer.
- The end event and a disarm write in the same cycle produce a single disarm; the tagged sample is still output with 11.
- An arm write while already armed restarts the sequencer: state=0, counters=0.
- rst mid-stream drops any held output sample. Table contents are retained.

## Configuration
- TRIGGER_SEQUENCER_EDGE_EN defined:
  - A MODE bit m=1 makes matcher m fire only on a transfer where it matches and did not match on the previous transferred sample.
  - The previous-match flag clears on reset and on arm.
- Undefined:
  - MODE writes are ignored and all matchers are level-sensitive.
  - No previous-match registers are built.

## Structure
- Package trigger_pkg holds:
  - event codes (EVT_NONE/START/TRIG/END);
  - register addresses;
  - entry field offset functions of TSW/TCN.
- Sub-module trigger_matcher: one mask/value compare with optional edge register, instantiated TMN times.
- Counters, table, control logic and output slice are inline.

## Test plan
- Pass-through and reset: disarmed, sample 0xA5A5A5A5 is sent with sto_tready=1. Required: it appears 1 cycle later with event 00; after rst, sto_tvalid=0.
- Simple trigger: load all entries with next=0 and evt=00, except entries for state 0 with match0=1, which have evt=10. With msk0=0xFF and val0=0x42, arm and send 0x41,0x42,0x43. Required events 00,10,00.
- Counter: entries with state 0 and match0=1 set inc0; the entry for done0=1 has evt=11. With lim0=3, send 4 matching samples. Required: 4th sample tagged 11, sts_armed falls, cnt0 holds 3 and does not wrap.
- Back-pressure: hold sto_tready=0 for 5 cycles with a valid output present. Required: sti_tready=0, output stable, no sample lost or duplicated, event order preserved.
- Table pointer wrap: write TBL_PTR=2**TAW-1, then 2 TBL_DAT writes. Required: entries land at the last index and at 0. A write to 0x09 while armed is ignored.
- Edge mode (TRIGGER_SEQUENCER_EDGE_EN): with MODE=1, send 0x42,0x42,0x00,0x42. Required: match0 is seen on the 1st and 4th samples only.

Source files
------------

// File: rtl/trigger_pkg.sv
// Shared definitions for the trigger sequencer: event codes, register map and table entry layout.
package trigger_pkg;

  typedef enum logic [1:0] {
    EVT_NONE  = 2'b00,
    EVT_START = 2'b01,
    EVT_TRIG  = 2'b10,
    EVT_END   = 2'b11
  } evt_e;

  localparam int ADDR_CTRL       = 0;
  localparam int ADDR_TBL_PTR    = 1;
  localparam int ADDR_TBL_DAT    = 2;
  localparam int ADDR_MODE       = 3;
  localparam int ADDR_MATCH_BASE = 8;
  localparam int ADDR_LIMIT_BASE = 32;

  // Entry layout, LSB first: next_state[TSW], inc[TCN], clr[TCN], evt[2].
  function automatic int fld_inc_lsb(input int tsw);
    return tsw;
  endfunction

  function automatic int fld_clr_lsb(input int tsw, input int tcn);
    return tsw + tcn;
  endfunction

  function automatic int fld_evt_lsb(input int tsw, input int tcn);
    return tsw + 2 * tcn;
  endfunction

endpackage

// File: rtl/trigger_matcher.sv
// One mask/value sample comparator; with TRIGGER_SEQUENCER_EDGE_EN it can fire on rising match only.
module trigger_matcher #(
  parameter int SDW = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [SDW-1:0] sample_i,
  input  logic [SDW-1:0] msk_i,
  input  logic [SDW-1:0] val_i,
  input  logic           edge_i,
  input  logic           xfer_i,
  input  logic           clr_i,
  output logic           match_o
);

  logic raw_s;

  assign raw_s = (((sample_i ^ val_i) & msk_i) == '0);

`ifdef TRIGGER_SEQUENCER_EDGE_EN
  logic prev_q;

  // Remember the raw match of the last transferred sample; arm restarts the history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else if (clr_i) begin
      prev_q <= 1'b0;
    end else if (xfer_i) begin
      prev_q <= raw_s;
    end else begin
      prev_q <= prev_q;
    end
  end

  assign match_o = raw_s & ~(edge_i & prev_q);
`else
  logic unused_s;

  assign unused_s = &{1'b0, clk, rst, edge_i, xfer_i, clr_i};
  assign match_o  = raw_s;
`endif

endmodule

// File: rtl/trigger_sequencer.sv
// Table-driven capture trigger with arm/disarm run control and a one-deep output slice.
// Optional edge-sensitive matchers are enabled with TRIGGER_SEQUENCER_EDGE_EN.
module trigger_sequencer
  import trigger_pkg::*;
#(
  parameter int BDW = 32,
  parameter int BAW = 6,
  parameter int SDW = 32,
  parameter int TMN = 4,
  parameter int TCN = 2,
  parameter int TCW = 16,
  parameter int TSW = 3,
  parameter int TEW = TSW + 2 * TCN + 2,
  parameter int TAW = TSW + TMN + TCN
) (
  input  logic           clk,
  input  logic           rst,
  output logic           bus_wready,
  input  logic           bus_wvalid,
  input  logic [BAW-1:0] bus_waddr,
  input  logic [BDW-1:0] bus_wdata,
  output logic           sti_tready,
  input  logic           sti_tvalid,
  input  logic [SDW-1:0] sti_tdata,
  input  logic           sto_tready,
  output logic           sto_tvalid,
  output logic [1:0]     sto_tevent,
  output logic [SDW-1:0] sto_tdata,
  output logic           sts_armed
);

  localparam int INC_LSB = fld_inc_lsb(TSW);
  localparam int CLR_LSB = fld_clr_lsb(TSW, TCN);
  localparam int EVT_LSB = fld_evt_lsb(TSW, TCN);
  localparam int TDEPTH  = 2 ** TAW;

  logic                    armed_q, armed_d;
  logic [TSW-1:0]          state_q, state_d;
  logic [TCN-1:0][TCW-1:0] cnt_q, cnt_d, lim_q;
  logic [TMN-1:0][SDW-1:0] msk_q, val_q;
  logic [TAW-1:0]          ptr_q;
  logic [TEW-1:0]          tbl_q [TDEPTH];
  logic                    sto_vld_q;
  logic [1:0]              sto_evt_q;
  logic [SDW-1:0]          sto_dat_q;

  logic           xfer_s, ctrl_we_s, cfg_we_s, arm_s, disarm_s;
  logic [TMN-1:0] match_s, mode_s;
  logic [TCN-1:0] done_s;
  logic [TEW-1:0] entry_s;
  evt_e           evt_s, out_evt_s;

  assign bus_wready = 1'b1;
  assign sti_tready = ~sto_vld_q | sto_tready;
  assign xfer_s     = sti_tvalid & sti_tready;
  assign ctrl_we_s  = bus_wvalid & (bus_waddr == BAW'(ADDR_CTRL));
  assign cfg_we_s   = bus_wvalid & ~armed_q & (bus_waddr != BAW'(ADDR_CTRL));
  assign disarm_s   = ctrl_we_s & bus_wdata[1];
  assign arm_s      = ctrl_we_s & bus_wdata[0] & ~bus_wdata[1];

`ifdef TRIGGER_SEQUENCER_EDGE_EN
  logic [TMN-1:0] mode_q;

  // Per-matcher edge-mode bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= '0;
    end else if (cfg_we_s && (bus_waddr == BAW'(ADDR_MODE))) begin
      mode_q <= bus_wdata[TMN-1:0];
    end else begin
      mode_q <= mode_q;
    end
  end

  assign mode_s = mode_q;
`else
  assign mode_s = '0;
`endif

  for (genvar m = 0; m < TMN; m++) begin : g_match
    trigger_matcher #(.SDW(SDW)) u_match (
      .clk      (clk),
      .rst      (rst),
      .sample_i (sti_tdata),
      .msk_i    (msk_q[m]),
      .val_i    (val_q[m]),
      .edge_i   (mode_s[m]),
      .xfer_i   (xfer_s),
      .clr_i    (arm_s),
      .match_o  (match_s[m])
    );
  end

  for (genvar c = 0; c < TCN; c++) begin : g_done
    assign done_s[c] = (cnt_q[c] == lim_q[c]);
  end

  assign entry_s   = tbl_q[{state_q, match_s, done_s}];
  assign evt_s     = evt_e'(entry_s[EVT_LSB +: 2]);
  assign out_evt_s = armed_q ? evt_s : EVT_NONE;

  // Table memory has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (cfg_we_s && (bus_waddr == BAW'(ADDR_TBL_DAT))) begin
      tbl_q[ptr_q] <= bus_wdata[TEW-1:0];
    end
  end

  // Configuration registers, writable only while disarmed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      msk_q <= '0;
      val_q <= '0;
      lim_q <= '0;
    end else if (cfg_we_s) begin
      if (bus_waddr == BAW'(ADDR_TBL_PTR)) begin
        ptr_q <= bus_wdata[TAW-1:0];
      end else if (bus_waddr == BAW'(ADDR_TBL_DAT)) begin
        ptr_q <= ptr_q + TAW'(1);
      end else begin
        ptr_q <= ptr_q;
      end
      for (int m = 0; m < TMN; m++) begin
        if (bus_waddr == BAW'(ADDR_MATCH_BASE + 2 * m)) msk_q[m] <= bus_wdata[SDW-1:0];
        if (bus_waddr == BAW'(ADDR_MATCH_BASE + 2 * m + 1)) val_q[m] <= bus_wdata[SDW-1:0];
      end
      for (int c = 0; c < TCN; c++) begin
        if (bus_waddr == BAW'(ADDR_LIMIT_BASE + c)) lim_q[c] <= bus_wdata[TCW-1:0];
      end
    end
  end

  // Run control restarts or stops the sequencer; otherwise armed transfers step the table.
  always_comb begin
    armed_d = armed_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (disarm_s || arm_s) begin
      armed_d = arm_s;
      state_d = '0;
      cnt_d   = '0;
    end else if (armed_q && xfer_s) begin
      state_d = entry_s[TSW-1:0];
      for (int c = 0; c < TCN; c++) begin
        if (entry_s[CLR_LSB + c]) begin
          cnt_d[c] = '0;
        end else if (entry_s[INC_LSB + c] && !done_s[c]) begin
          cnt_d[c] = cnt_q[c] + TCW'(1);
        end else begin
          cnt_d[c] = cnt_q[c];
        end
      end
      if (evt_s == EVT_END) begin
        armed_d = 1'b0;
        state_d = '0;
        cnt_d   = '0;
      end else begin
        armed_d = armed_q;
      end
    end else begin
      armed_d = armed_q;
      state_d = state_q;
      cnt_d   = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q <= 1'b0;
      state_q <= '0;
      cnt_q   <= '0;
    end else begin
      armed_q <= armed_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output slice: reload whenever the downstream side can accept, hold under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sto_vld_q <= 1'b0;
      sto_evt_q <= 2'b00;
      sto_dat_q <= '0;
    end else if (sti_tready) begin
      sto_vld_q <= sti_tvalid;
      if (sti_tvalid) begin
        sto_dat_q <= sti_tdata;
        sto_evt_q <= out_evt_s;
      end
    end
  end

  assign sto_tvalid = sto_vld_q;
  assign sto_tevent = sto_evt_q;
  assign sto_tdata  = sto_dat_q;
  assign sts_armed  = armed_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Self-checking bench for trigger_sequencer: spec-level model plus directed scenarios.
module tb_trigger_sequencer;

  localparam int K_ZERO    = 0;
  localparam int K_TRIG    = 1;
  localparam int K_CNT_END = 2;
  localparam int K_CNT_SAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_wready;
  logic        bus_wvalid = 1'b0;
  logic [5:0]  bus_waddr = 6'd0;
  logic [31:0] bus_wdata = 32'd0;
  logic        sti_tready;
  logic        sti_tvalid = 1'b0;
  logic [31:0] sti_tdata = 32'd0;
  logic        sto_tready = 1'b1;
  logic        sto_tvalid;
  logic [1:0]  sto_tevent;
  logic [31:0] sto_tdata;
  logic        sts_armed;

  trigger_sequencer dut (
    .clk(clk), .rst(rst),
    .bus_wready(bus_wready), .bus_wvalid(bus_wvalid), .bus_waddr(bus_waddr), .bus_wdata(bus_wdata),
    .sti_tready(sti_tready), .sti_tvalid(sti_tvalid), .sti_tdata(sti_tdata),
    .sto_tready(sto_tready), .sto_tvalid(sto_tvalid), .sto_tevent(sto_tevent), .sto_tdata(sto_tdata),
    .sts_armed(sts_armed)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] d; logic [1:0] e; } item_t;
  item_t      exp_q[$];
  logic [1:0] obs_q[$];
  int n_chk = 0;
  int n_fail = 0;

  // Spec-level model state
  int m_tbl[int];
  int m_msk[4], m_val[4], m_lim[2], m_cnt[2];
  int m_mode, m_ptr, m_state;
  bit m_armed;
  bit m_prev[4];

  bit          stall_prev = 1'b0;
  logic [31:0] stall_d;
  logic [1:0]  stall_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 4; m++) begin m_msk[m] = 0; m_val[m] = 0; m_prev[m] = 0; end
    for (int c = 0; c < 2; c++) begin m_lim[c] = 0; m_cnt[c] = 0; end
    m_mode = 0; m_ptr = 0; m_state = 0; m_armed = 0;
    exp_q.delete();
    stall_prev = 0;
  endtask

  // Apply the effect of the coming clock edge to the model, given the inputs now on the pins.
  task automatic model_step();
    bit was_armed = m_armed;
    int a, w;
    if (sti_tvalid && sti_tready) begin
      int idx, e, ev;
      bit raw[4];
      idx = m_state * 64;
      for (int m = 0; m < 4; m++) begin
        bit fire;
        raw[m] = (((sti_tdata ^ m_val[m]) & m_msk[m]) == 0);
        fire = raw[m];
`ifdef TRIGGER_SEQUENCER_EDGE_EN
        if (((m_mode >> m) & 1) != 0 && m_prev[m]) fire = 0;
`endif
        if (fire) idx += (4 << m);
      end
      for (int c = 0; c < 2; c++) if (m_cnt[c] == m_lim[c]) idx += (1 << c);
      e  = m_tbl.exists(idx) ? m_tbl[idx] : 0;
      ev = 0;
      if (m_armed) begin
        ev = (e >> 7) & 3;
        for (int c = 0; c < 2; c++) begin
          if (((e >> (5 + c)) & 1) != 0) m_cnt[c] = 0;
          else if (((e >> (3 + c)) & 1) != 0 && m_cnt[c] != m_lim[c]) m_cnt[c]++;
        end
        m_state = e & 7;
        if (ev == 3) begin m_armed = 0; m_state = 0; m_cnt[0] = 0; m_cnt[1] = 0; end
      end
      exp_q.push_back('{d: sti_tdata, e: ev[1:0]});
      for (int m = 0; m < 4; m++) m_prev[m] = raw[m];
    end
    if (bus_wvalid) begin
      a = int'(bus_waddr);
      w = bus_wdata;
      if (a == 0) begin
        if ((w & 2) != 0) begin
          m_armed = 0; m_state = 0; m_cnt[0] = 0; m_cnt[1] = 0;
        end else if ((w & 1) != 0) begin
          m_armed = 1; m_state = 0; m_cnt[0] = 0; m_cnt[1] = 0;
          for (int m = 0; m < 4; m++) m_prev[m] = 0;
        end
      end else if (!was_armed) begin
        case (a)
          1: m_ptr = w & 511;
          2: begin m_tbl[m_ptr] = w & 511; m_ptr = (m_ptr + 1) & 511; end
          3: m_mode = w & 15;
          32, 33: m_lim[a - 32] = w & 32'hFFFF;
          default: begin
            if (a >= 8 && a < 16) begin
              if (a % 2 == 1) m_val[(a - 8) / 2] = w;
              else m_msk[(a - 8) / 2] = w;
            end
          end
        endcase
      end
    end
  endtask

  // Compare process: checks outputs against the model every cycle, then advances the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("sts_armed", sts_armed, m_armed);
      chk("sti_tready", sti_tready, !sto_tvalid || sto_tready);
      if (stall_prev) begin
        chk("stall_valid", sto_tvalid, 1);
        chk("stall_data", sto_tdata, stall_d);
        chk("stall_event", sto_tevent, stall_e);
      end
      if (sto_tvalid && sto_tready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL spurious_output: data 0x%0h with no expected sample", sto_tdata);
        end else begin
          item_t it;
          it = exp_q.pop_front();
          chk("out_data", sto_tdata, it.d);
          chk("out_event", sto_tevent, it.e);
          obs_q.push_back(sto_tevent);
        end
      end
      stall_prev = sto_tvalid && !sto_tready;
      stall_d = sto_tdata;
      stall_e = sto_tevent;
      model_step();
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input int a, input int d);
    bus_wvalid = 1'b1; bus_waddr = a[5:0]; bus_wdata = d;
    @(posedge clk); #1;
    bus_wvalid = 1'b0;
  endtask

  task automatic send(input logic [31:0] d);
    bit ok = 0;
    int n = 0;
    sti_tvalid = 1'b1; sti_tdata = d;
    while (!ok && n < 50) begin
      @(negedge clk); ok = sti_tready;
      @(posedge clk); #1; n++;
    end
    sti_tvalid = 1'b0;
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: sample 0x%0h not accepted within 50 cycles", d);
    end
  endtask

  // Entry fields: next[2:0], inc[4:3], clr[6:5], evt[8:7]; index = {state, match[3:0], done[1:0]}.
  function automatic int entry_for(input int kind, input int idx);
    int st = idx >> 6;
    int m0 = (idx >> 2) & 1;
    int d0 = idx & 1;
    int e = 0;
    case (kind)
      K_TRIG:    if (st == 0 && m0 == 1) e = 2 << 7;
      K_CNT_END: begin
        if (st == 0 && m0 == 1) e |= 1 << 3;
        if (st == 0 && m0 == 0) e |= 1 << 5;
        if (st == 0 && d0 == 1) e |= 3 << 7;
      end
      K_CNT_SAT: begin
        if (st == 0 && m0 == 1) e |= 1 << 3;
        if (st == 0 && d0 == 1) e |= 2 << 7;
      end
      default: e = 0;
    endcase
    return e;
  endfunction

  task automatic fill(input int kind);
    wr(1, 0);
    for (int i = 0; i < 512; i++) wr(2, entry_for(kind, i));
  endtask

  // Event i of the observed sequence is expected at seq[2i+1:2i].
  task automatic expect_obs(input string name, input int n, input logic [15:0] seq);
    idle(3);
    chk({name, "_count"}, obs_q.size(), n);
    for (int i = 0; i < n && i < obs_q.size(); i++)
      chk($sformatf("%s_evt%0d", name, i), obs_q[i], seq[2*i +: 2]);
    obs_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    chk("rst_tvalid", sto_tvalid, 0);
    chk("rst_tevent", sto_tevent, 0);
    chk("rst_tdata", sto_tdata, 0);
    chk("rst_armed", sts_armed, 0);
    chk("rst_wready", bus_wready, 1);

    // Pass-through while disarmed
    send(32'hA5A5A5A5);
    chk("pt_valid", sto_tvalid, 1);
    chk("pt_data", sto_tdata, 32'hA5A5A5A5);
    chk("pt_event", sto_tevent, 0);
    expect_obs("passthru", 1, 16'h0000);

    // Simple trigger
    fill(K_TRIG);
    wr(8, 32'hFF); wr(9, 32'h42); wr(0, 1);
    send(32'h41); send(32'h42); send(32'h43);
    expect_obs("trig", 3, 16'h0008);

    // Reset mid-stream drops the held sample
    sto_tready = 1'b0;
    send(32'h77);
    idle(1);
    rst = 1'b1;
    #1;
    chk("midrst_valid", sto_tvalid, 0);
    chk("midrst_armed", sts_armed, 0);
    model_reset();
    idle(2);
    sto_tready = 1'b1;
    rst = 1'b0;
    obs_q.delete();

    // Table survives reset
    wr(8, 32'hFF); wr(9, 32'h42); wr(0, 1);
    send(32'h42);
    expect_obs("retain", 1, 16'h0002);
    wr(0, 2);

    // Counter to end, with a clear in the middle
    fill(K_CNT_END);
    wr(32, 3); wr(0, 1);
    send(32'h42); send(32'h42); send(32'h00); send(32'h42);
    send(32'h42); send(32'h42); send(32'h42);
    chk("end_disarms", sts_armed, 0);
    send(32'h99);
    expect_obs("cnt_end", 8, 16'h3000);

    // Counter saturates at its limit
    fill(K_CNT_SAT);
    wr(0, 1);
    for (int i = 0; i < 6; i++) send(32'h42);
    expect_obs("cnt_sat", 6, 16'h0A80);
    wr(0, 2);

    // Back-pressure for 5 cycles
    fill(K_TRIG);
    wr(0, 1);
    sto_tready = 1'b0;
    send(32'h42);
    chk("bp_tready", sti_tready, 0);
    fork
      begin idle(5); sto_tready = 1'b1; end
      begin send(32'h41); send(32'h42); send(32'h43); end
    join
    expect_obs("backpressure", 4, 16'h0022);
    wr(0, 2);

    // Table pointer wrap and a config write ignored while armed
    fill(K_ZERO);
    for (int m = 0; m < 4; m++) begin wr(8 + 2*m, 32'hFF); wr(9 + 2*m, 32'h42); end
    wr(32, 1); wr(33, 1);
    wr(1, 511); wr(2, 256); wr(2, 159);
    wr(0, 1);
    wr(9, 0);
    send(32'h00); send(32'h42);
    expect_obs("ptr_wrap", 2, 16'h0009);
    wr(0, 2);

    // Edge mode on matcher 0
    fill(K_TRIG);
    wr(3, 1); wr(0, 1);
    send(32'h42); send(32'h42); send(32'h00); send(32'h42);
`ifdef TRIGGER_SEQUENCER_EDGE_EN
    expect_obs("edge", 4, 16'h0082);
`else
    expect_obs("edge", 4, 16'h008A);
`endif
    wr(0, 2);

    idle(5);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
